// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit path: arbiter FSM encodings and 8N1 frame timing.
package uart_tx_arbiter_pkg;

  localparam int unsigned NbDataDefault = 8;

  typedef logic [2:0] state_t;

  // One-hot so each state decodes from a single flop.
  localparam state_t StIdle = 3'b001;
  localparam state_t StLoad = 3'b010;
  localparam state_t StWait = 3'b100;

  localparam int unsigned ClkHz          = 100_000_000;
  localparam int unsigned BaudRate       = 9600;
  localparam int unsigned FrameBits      = 10;
  localparam int unsigned CyclesPerBit   = ClkHz / BaudRate;
  localparam int unsigned CyclesPerFrame = CyclesPerBit * FrameBits;

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request strictly after ptr_i, wrapping.
module uart_tx_arbiter_rr_priority_picker #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         winner_o,
  output logic [$clog2(N_REQ)-1:0] winner_idx_o
);

  localparam int unsigned PtrW = $clog2(N_REQ);

  logic [PtrW-1:0] idx;

  // Scan from farthest to nearest so the nearest set request overwrites the others.
  always_comb begin
    winner_o     = '0;
    winner_idx_o = '0;
    idx          = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      idx = PtrW'((32'(ptr_i) + i) % N_REQ);
      if (req_i[idx]) begin
        winner_o      = '0;
        winner_o[idx] = 1'b1;
        winner_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ byte producers: round-robin grant, locked bursts with a
// length cap, and a watchdog on the transmitter's done pulse.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NB_DATA        = NbDataDefault,
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_DATA-1:0] i_data,
  input  logic [N_REQ-1:0]         i_last,
  input  logic                     i_tx_done,
  output logic [N_REQ-1:0]         o_ack,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_tx_start,
  output logic [NB_DATA-1:0]       o_tx_data,
  output logic                     o_busy,
  output logic                     o_timeout
);

  localparam int unsigned PtrW   = $clog2(N_REQ);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);

  state_t               state_q, state_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [PtrW-1:0]      owner_q, owner_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 start_q, start_d;
  logic [NB_DATA-1:0]   data_q, data_d;
  logic                 lock_q, lock_d;
  logic [BurstW-1:0]    burst_q, burst_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;

  logic [N_REQ-1:0]     pick_oh;
  logic [PtrW-1:0]      pick_idx;
  logic                 accept;
  logic                 release_own;
  logic [N_REQ-1:0]     acc_oh;
  logic [PtrW-1:0]      acc_idx;
  logic [NB_DATA-1:0]   acc_data;

  uart_tx_arbiter_rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i        (i_req),
    .ptr_i        (ptr_q),
    .winner_o     (pick_oh),
    .winner_idx_o (pick_idx)
  );

  always_comb begin
    acc_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (acc_idx == PtrW'(k)) begin
        acc_data = i_data[k*NB_DATA +: NB_DATA];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    data_d      = data_q;
    lock_d      = lock_q;
    burst_d     = burst_q;
    timer_d     = timer_q;
    ack_d       = '0;
    start_d     = 1'b0;
    timeout_d   = 1'b0;
    accept      = 1'b0;
    release_own = 1'b0;
    acc_oh      = grant_q;
    acc_idx     = owner_q;

    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          accept  = 1'b1;
          acc_oh  = pick_oh;
          acc_idx = pick_idx;
          burst_d = BurstW'(1);
        end
      end
      StLoad: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        if (i_tx_done) begin
          // Continue a locked burst only while the owner still has a byte and the cap allows it.
          if (lock_q && i_req[owner_q] && (burst_q < BurstW'(MAX_BURST))) begin
            accept  = 1'b1;
            burst_d = burst_q + 1'b1;
          end else begin
            release_own = 1'b1;
          end
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          release_own = 1'b1;
          timeout_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = StLoad;
      owner_d = acc_idx;
      grant_d = acc_oh;
      ack_d   = acc_oh;
      start_d = 1'b1;
      data_d  = acc_data;
      lock_d  = ~i_last[acc_idx];
    end

    if (release_own) begin
      state_d = StIdle;
      ptr_d   = owner_q;
      grant_d = '0;
      lock_d  = 1'b0;
      burst_d = '0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      ptr_q     <= PtrW'(N_REQ - 1);
      owner_q   <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      lock_q    <= 1'b0;
      burst_q   <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      start_q   <= start_d;
      data_q    <= data_d;
      lock_q    <= lock_d;
      burst_q   <= burst_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_grant    = grant_q;
  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;

endmodule
